tone_sequencer: RTL and testbench

TONE_SEQUENCER -- requirements
Module: tone_sequencer

---
 rtl/tone_sequencer.sv | 139 +++++++++++++
 tb/tb_tone_sequencer.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/tone_sequencer.sv
// Prioritised tone sequencer: queues edge-detected sound requests and plays each as a
// fixed-length prescaler tone followed by an optional silent gap.
module tone_sequencer #(
  parameter int unsigned NUM_CH     = 6,
  parameter int unsigned PRESCALE_W = 10,
  parameter logic [NUM_CH*PRESCALE_W-1:0] PRESCALE_TABLE =
    {10'h117, 10'h18B, 10'h0DD, 10'h128, 10'h14C, 10'h175},
  parameter int unsigned TONE_CYCLES = 2_500_000,
  parameter int unsigned GAP_CYCLES  = 250_000,
  parameter bit          PREEMPT     = 1'b1,
  localparam int unsigned ChW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_CH-1:0]     req,
  input  logic                  mute,
  output logic [PRESCALE_W-1:0] preScaleValue,
  output logic                  soundOn,
  output logic [ChW-1:0]        activeCh
);

  localparam int unsigned CntMax0 = (TONE_CYCLES > GAP_CYCLES) ? TONE_CYCLES : GAP_CYCLES;
  localparam int unsigned CntMax  = (CntMax0 > 2) ? CntMax0 : 2;
  localparam int unsigned CntW    = $clog2(CntMax);
  localparam logic [CntW-1:0] ToneLoad = CntW'(TONE_CYCLES - 1);
  localparam logic [CntW-1:0] GapLoad  = CntW'((GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StPlay, StGap} state_e;

  state_e                  state_q, state_d;
  logic [NUM_CH-1:0]       req_q, req_prev_q;
  logic [NUM_CH-1:0]       pending_q, pending_d;
  logic [CntW-1:0]         cnt_q, cnt_d;
  logic [PRESCALE_W-1:0]   psv_q, psv_d;
  logic                    sound_q, sound_d;
  logic [ChW-1:0]          act_q, act_d;

  logic [NUM_CH-1:0]       edge_vec;
  logic [NUM_CH-1:0]       clr_vec;
  logic [ChW-1:0]          sel_idx;
  logic                    start;

  // req is registered once before edge detection, so a request sampled at one edge
  // reaches the outputs two edges later.
  assign edge_vec = req_q & ~req_prev_q;

  always_comb begin
    sel_idx = '0;
    for (int i = int'(NUM_CH) - 1; i >= 0; i--) begin
      if (pending_q[i]) sel_idx = ChW'(i);
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    psv_d   = psv_q;
    sound_d = sound_q;
    act_d   = act_q;
    clr_vec = '0;
    start   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (|pending_q) start = 1'b1;
      end
      StPlay: begin
        // Preemption takes precedence over normal completion so no gap is inserted.
        if (PREEMPT && (|pending_q) && (sel_idx < act_q)) begin
          start = 1'b1;
        end else if (cnt_q == '0) begin
          sound_d = 1'b0;
          psv_d   = '0;
          if (GAP_CYCLES != 0) begin
            state_d = StGap;
            cnt_d   = GapLoad;
          end else begin
            state_d = StIdle;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StGap: begin
        if (cnt_q == '0) state_d = StIdle;
        else             cnt_d   = cnt_q - 1'b1;
      end
      default: state_d = StIdle;
    endcase

    if (start) begin
      clr_vec[sel_idx] = 1'b1;
      state_d          = StPlay;
      cnt_d            = ToneLoad;
      psv_d            = PRESCALE_TABLE[int'(sel_idx)*PRESCALE_W +: PRESCALE_W];
      sound_d          = 1'b1;
      act_d            = sel_idx;
    end

    // A set wins over a clear landing on the same bit.
    pending_d = (pending_q & ~clr_vec) | edge_vec;

    if (mute) begin
      state_d   = StIdle;
      cnt_d     = '0;
      psv_d     = '0;
      sound_d   = 1'b0;
      act_d     = '0;
      pending_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      req_q      <= '0;
      req_prev_q <= '0;
      pending_q  <= '0;
      cnt_q      <= '0;
      psv_q      <= '0;
      sound_q    <= 1'b0;
      act_q      <= '0;
    end else begin
      state_q    <= state_d;
      req_q      <= req;
      req_prev_q <= req_q;
      pending_q  <= pending_d;
      cnt_q      <= cnt_d;
      psv_q      <= psv_d;
      sound_q    <= sound_d;
      act_q      <= act_d;
    end
  end

  assign preScaleValue = psv_q;
  assign soundOn       = sound_q;
  assign activeCh      = act_q;

endmodule

// File: tb/tb_tone_sequencer.sv
// Directed bench for tone_sequencer: one preempting and one non-preempting instance share
// stimulus; expected tones are hand-computed with TONE_CYCLES=4, GAP_CYCLES=2.
module tb_tone_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] req;
  logic       mute;
  logic [9:0] psv, psv_np;
  logic       on, on_np;
  logic [2:0] ch, ch_np;

  int checks = 0;
  int errors = 0;
  int on_cnt, on_cnt_np, starts;
  logic prev_on;

  always #5 clk = ~clk;

  tone_sequencer #(.TONE_CYCLES(4), .GAP_CYCLES(2), .PREEMPT(1'b1)) u_dut (
    .clk(clk), .reset(reset), .req(req), .mute(mute),
    .preScaleValue(psv), .soundOn(on), .activeCh(ch)
  );

  tone_sequencer #(.TONE_CYCLES(4), .GAP_CYCLES(2), .PREEMPT(1'b0)) u_np (
    .clk(clk), .reset(reset), .req(req), .mute(mute),
    .preScaleValue(psv_np), .soundOn(on_np), .activeCh(ch_np)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Channel is only compared while a tone is expected.
  task automatic check_tone(input bit np, input string tag, input logic [9:0] e_psv,
                            input logic e_on, input logic [2:0] e_ch);
    if (!np) begin
      check_eq({tag, ".psv"}, 32'(psv), 32'(e_psv));
      check_eq({tag, ".on"}, 32'(on), 32'(e_on));
      if (e_on) check_eq({tag, ".ch"}, 32'(ch), 32'(e_ch));
    end else begin
      check_eq({tag, ".psv_np"}, 32'(psv_np), 32'(e_psv));
      check_eq({tag, ".on_np"}, 32'(on_np), 32'(e_on));
      if (e_on) check_eq({tag, ".ch_np"}, 32'(ch_np), 32'(e_ch));
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    req   = '0;
    mute  = 1'b0;
    tick(3);
    check_tone(0, "rst", 10'h0, 1'b0, 3'd0);
    check_tone(1, "rst", 10'h0, 1'b0, 3'd0);
    check_eq("rst_ch", 32'(ch), 32'd0);
    reset = 1'b0;
    tick(2);

    // Single pulse on ch2: tone t+2..t+5, gap t+6..t+7.
    req = 6'b000100; tick(1); req = '0;
    tick(1); check_tone(0, "single_lat", 10'h0, 1'b0, 3'd0);
    for (int k = 0; k < 4; k++) begin tick(1); check_tone(0, "single_on", 10'h128, 1'b1, 3'd2); end
    for (int k = 0; k < 2; k++) begin tick(1); check_tone(0, "single_gap", 10'h0, 1'b0, 3'd0); end
    tick(3); check_tone(0, "single_idle", 10'h0, 1'b0, 3'd0);

    // Simultaneous ch4 and ch1 without preemption: ch1, gap, ch4.
    req = 6'b010010; tick(1); req = '0;
    tick(1); check_tone(1, "pair_lat", 10'h0, 1'b0, 3'd0);
    for (int k = 0; k < 4; k++) begin tick(1); check_tone(1, "pair_first", 10'h14C, 1'b1, 3'd1); end
    for (int k = 0; k < 3; k++) begin tick(1); check_tone(1, "pair_gap", 10'h0, 1'b0, 3'd0); end
    for (int k = 0; k < 4; k++) begin tick(1); check_tone(1, "pair_second", 10'h18B, 1'b1, 3'd4); end
    for (int k = 0; k < 2; k++) begin tick(1); check_tone(1, "pair_gap2", 10'h0, 1'b0, 3'd0); end
    tick(2);

    // Preemption: ch3 playing, ch0 sampled at t+3 starts at t+5 with no gap.
    req = 6'b001000; tick(1); req = '0;
    tick(2); check_tone(0, "pre_ch3", 10'h0DD, 1'b1, 3'd3);
    req = 6'b000001; tick(1); req = '0;
    check_tone(0, "pre_ch3b", 10'h0DD, 1'b1, 3'd3);
    tick(1); check_tone(0, "pre_ch3c", 10'h0DD, 1'b1, 3'd3);
    tick(1);
    check_tone(0, "pre_start", 10'h175, 1'b1, 3'd0);
    check_tone(1, "np_keeps", 10'h0DD, 1'b1, 3'd3);
    for (int k = 0; k < 3; k++) begin tick(1); check_tone(0, "pre_run", 10'h175, 1'b1, 3'd0); end
    on_cnt = 0;
    for (int k = 0; k < 8; k++) begin
      tick(1);
      on_cnt += int'(on);
      if (k == 0) check_tone(1, "np_after_gap", 10'h175, 1'b1, 3'd0);
    end
    check_eq("pre_no_resume", 32'(on_cnt), 32'd0);

    // Held request yields exactly one tone.
    on_cnt = 0; starts = 0; prev_on = 1'b0;
    req = 6'b100000;
    for (int k = 0; k < 30; k++) begin
      tick(1);
      if (k == 19) req = '0;
      on_cnt += int'(on);
      if (on && !prev_on) starts++;
      if (on) check_eq("held_psv", 32'(psv), 32'h117);
      prev_on = on;
    end
    check_eq("held_on_cycles", 32'(on_cnt), 32'd4);
    check_eq("held_starts", 32'(starts), 32'd1);

    // Mute mid-tone with ch1 pending, then req held through mute.
    req = 6'b000001; tick(1); req = '0;
    tick(2); check_tone(0, "mute_pre", 10'h175, 1'b1, 3'd0);
    req = 6'b000010; tick(1); req = '0;
    tick(1); mute = 1'b1;
    tick(1);
    check_tone(0, "mute_now", 10'h0, 1'b0, 3'd0);
    check_tone(1, "mute_now", 10'h0, 1'b0, 3'd0);
    check_eq("mute_ch", 32'(ch), 32'd0);
    req = 6'b000100;
    tick(2); mute = 1'b0;
    on_cnt = 0; on_cnt_np = 0;
    for (int k = 0; k < 10; k++) begin
      tick(1);
      on_cnt += int'(on);
      on_cnt_np += int'(on_np);
    end
    check_eq("mute_flush", 32'(on_cnt), 32'd0);
    check_eq("mute_flush_np", 32'(on_cnt_np), 32'd0);
    req = '0;
    tick(3);

    // Reset mid-gap with ch0 pending.
    req = 6'b000100; tick(1); req = '0;
    tick(5); check_tone(0, "rgap_on", 10'h128, 1'b1, 3'd2);
    req = 6'b000001; tick(1); req = '0;
    check_tone(0, "rgap_gap", 10'h0, 1'b0, 3'd0);
    tick(1); reset = 1'b1;
    tick(1);
    check_tone(0, "rgap_rst", 10'h0, 1'b0, 3'd0);
    check_tone(1, "rgap_rst", 10'h0, 1'b0, 3'd0);
    check_eq("rgap_ch", 32'(ch), 32'd0);
    reset = 1'b0;
    on_cnt = 0;
    for (int k = 0; k < 10; k++) begin tick(1); on_cnt += int'(on); end
    check_eq("rgap_no_tone", 32'(on_cnt), 32'd0);

    // Request high at the first post-reset edge counts as an edge.
    reset = 1'b1; req = 6'b010000;
    tick(2); reset = 1'b0;
    tick(2); check_tone(0, "post_rst_lat", 10'h0, 1'b0, 3'd0);
    tick(1); check_tone(0, "post_rst_on", 10'h18B, 1'b1, 3'd4);
    req = '0;
    tick(8);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
